// File: rtl/csc_pkg.sv
// Shared colour-space-conversion definitions: mode encoding, coefficient table
// and the luma offset, all parameterised by bit depth and fixed-point precision.
package csc_pkg;

  typedef enum logic [1:0] {
    MODE_601_FULL = 2'd0,
    MODE_601_LIM  = 2'd1,
    MODE_709_FULL = 2'd2,
    MODE_709_LIM  = 2'd3
  } csc_mode_e;

  typedef struct packed {
    logic signed [31:0] ky;
    logic signed [31:0] kr;
    logic signed [31:0] kgu;
    logic signed [31:0] kgv;
    logic signed [31:0] kb;
  } csc_coef_t;

  localparam int COEF_BASE_FRAC = 10;

  // Table is stored at 10 fractional bits; other precisions round-half-up.
  function automatic int scale_coef(input int k, input int frac);
    if (frac >= COEF_BASE_FRAC) return k <<< (frac - COEF_BASE_FRAC);
    return (k + (1 <<< (COEF_BASE_FRAC - frac - 1))) >>> (COEF_BASE_FRAC - frac);
  endfunction

  function automatic csc_coef_t csc_coef(input csc_mode_e mode, input int frac);
    csc_coef_t c;
    case (mode)
      MODE_601_LIM:  c = '{32'sd1192, 32'sd1634, 32'sd401, 32'sd833, 32'sd2066};
      MODE_709_FULL: c = '{32'sd1024, 32'sd1613, 32'sd192, 32'sd479, 32'sd1900};
      MODE_709_LIM:  c = '{32'sd1192, 32'sd1836, 32'sd218, 32'sd546, 32'sd2163};
      default:       c = '{32'sd1024, 32'sd1436, 32'sd352, 32'sd731, 32'sd1815};
    endcase
    c.ky  = scale_coef(c.ky,  frac);
    c.kr  = scale_coef(c.kr,  frac);
    c.kgu = scale_coef(c.kgu, frac);
    c.kgv = scale_coef(c.kgv, frac);
    c.kb  = scale_coef(c.kb,  frac);
    return c;
  endfunction

  function automatic int off_y(input int bpc, input csc_mode_e mode);
    if (mode == MODE_601_LIM || mode == MODE_709_LIM) return 16 <<< (bpc - 8);
    return 0;
  endfunction

endpackage

// File: rtl/yuv2rgb_pipe_if.sv
// Pixel stream bundle for the converter: YUV input side and RGB output side.
interface yuv2rgb_pipe_if #(
  parameter int C_BPC    = 8,
  parameter int C_USER_W = 3
);
  logic [1:0]          MODE_I;
  logic                VLD_I;
  logic                RDY_O;
  logic                SOF_I;
  logic [C_BPC-1:0]    Y_I;
  logic [C_BPC-1:0]    U_I;
  logic [C_BPC-1:0]    V_I;
  logic [C_USER_W-1:0] USER_I;
  logic                VLD_O;
  logic                RDY_I;
  logic [C_BPC-1:0]    R_O;
  logic [C_BPC-1:0]    G_O;
  logic [C_BPC-1:0]    B_O;
  logic                SOF_O;
  logic [C_USER_W-1:0] USER_O;

  modport slave (
    input  MODE_I, VLD_I, SOF_I, Y_I, U_I, V_I, USER_I, RDY_I,
    output RDY_O, VLD_O, R_O, G_O, B_O, SOF_O, USER_O
  );

  modport master (
    output MODE_I, VLD_I, SOF_I, Y_I, U_I, V_I, USER_I, RDY_I,
    input  RDY_O, VLD_O, R_O, G_O, B_O, SOF_O, USER_O
  );
endinterface

// File: rtl/csc_channel_clamp.sv
// One colour channel's tail: stage 3 adds the rounding half-LSB, stage 4
// shifts out the fraction and saturates into [0, 2^C_BPC-1].
module csc_channel_clamp #(
  parameter int C_BPC  = 8,
  parameter int C_FRAC = 10,
  parameter int W      = C_BPC + C_FRAC + 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic signed [W-1:0] i_sum,
  output logic [C_BPC-1:0]    o_pix
);
  localparam logic signed [W-1:0] RND     = W'(2 ** (C_FRAC - 1));
  localparam logic signed [W-1:0] PIX_MAX = W'(2 ** C_BPC - 1);

  logic signed [W-1:0] r_sum;
  logic signed [W-1:0] w_shr;
  logic [C_BPC-1:0]    w_clamp;

  assign w_shr = r_sum >>> C_FRAC;

  always_comb begin
    if (w_shr < 0)            w_clamp = '0;
    else if (w_shr > PIX_MAX) w_clamp = '1;
    else                      w_clamp = w_shr[C_BPC-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      o_pix <= '0;
    end else if (i_en) begin
      r_sum <= i_sum + RND;
      o_pix <= w_clamp;
    end
  end
endmodule

// File: rtl/yuv2rgb_pipe.sv
// Four-stage YUV -> RGB converter with a single global stall enable; SOF and
// sideband ride along in a shift register so they stay aligned with the data.
module yuv2rgb_pipe
  import csc_pkg::*;
#(
  parameter int C_BPC    = 8,
  parameter int C_FRAC   = 10,
  parameter int C_USER_W = 3
) (
  input logic           CLK_I,
  input logic           RSTN_I,
  yuv2rgb_pipe_if.slave bus
);
  localparam int STAGES = 4;
  localparam int D_W    = C_BPC + 1;
  localparam int W      = C_BPC + C_FRAC + 4;
  localparam int HALF   = 2 ** (C_BPC - 1);

  logic [STAGES:1]                r_vld_pipe;
  logic [STAGES:1]                r_sof_pipe;
  logic [STAGES:1][C_USER_W-1:0]  r_user_pipe;
  logic                           w_en;

  // The whole pipe only freezes when a finished beat is being refused.
  assign w_en      = bus.RDY_I | ~r_vld_pipe[STAGES];
  assign bus.RDY_O = w_en;

  // A SOF beat takes its own mode immediately; otherwise the frame's mode holds.
  csc_mode_e r_mode;
  csc_mode_e w_mode;
  assign w_mode = (bus.VLD_I && bus.SOF_I) ? csc_mode_e'(bus.MODE_I) : r_mode;

  logic signed [D_W-1:0] w_yd, w_cu, w_cv;
  assign w_yd = $signed({1'b0, bus.Y_I}) - D_W'(off_y(C_BPC, w_mode));
  assign w_cu = $signed({1'b0, bus.U_I}) - D_W'(HALF);
  assign w_cv = $signed({1'b0, bus.V_I}) - D_W'(HALF);

  csc_mode_e             r_s1_mode;
  logic signed [D_W-1:0] r_s1_yd, r_s1_cu, r_s1_cv;

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_mode    <= MODE_601_FULL;
      r_s1_mode <= MODE_601_FULL;
      r_s1_yd   <= '0;
      r_s1_cu   <= '0;
      r_s1_cv   <= '0;
    end else if (w_en) begin
      r_mode    <= w_mode;
      r_s1_mode <= w_mode;
      r_s1_yd   <= w_yd;
      r_s1_cu   <= w_cu;
      r_s1_cv   <= w_cv;
    end
  end

  csc_coef_t           w_k;
  logic signed [W-1:0] r_p_ky, r_p_kr, r_p_kgu, r_p_kgv, r_p_kb;

  assign w_k = csc_coef(r_s1_mode, C_FRAC);

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_p_ky  <= '0;
      r_p_kr  <= '0;
      r_p_kgu <= '0;
      r_p_kgv <= '0;
      r_p_kb  <= '0;
    end else if (w_en) begin
      r_p_ky  <= W'(longint'(r_s1_yd) * longint'(w_k.ky));
      r_p_kr  <= W'(longint'(r_s1_cv) * longint'(w_k.kr));
      r_p_kgu <= W'(longint'(r_s1_cu) * longint'(w_k.kgu));
      r_p_kgv <= W'(longint'(r_s1_cv) * longint'(w_k.kgv));
      r_p_kb  <= W'(longint'(r_s1_cu) * longint'(w_k.kb));
    end
  end

  logic [2:0][W-1:0]     w_sum;
  logic [2:0][C_BPC-1:0] w_pix;

  assign w_sum[0] = r_p_ky + r_p_kr;
  assign w_sum[1] = r_p_ky - r_p_kgu - r_p_kgv;
  assign w_sum[2] = r_p_ky + r_p_kb;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    csc_channel_clamp #(
      .C_BPC (C_BPC),
      .C_FRAC(C_FRAC),
      .W     (W)
    ) u_ch (
      .clk  (CLK_I),
      .rst_n(RSTN_I),
      .i_en (w_en),
      .i_sum(w_sum[c]),
      .o_pix(w_pix[c])
    );
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_vld_pipe  <= '0;
      r_sof_pipe  <= '0;
      r_user_pipe <= '0;
    end else if (w_en) begin
      r_vld_pipe  <= {r_vld_pipe[STAGES-1:1], bus.VLD_I};
      r_sof_pipe  <= {r_sof_pipe[STAGES-1:1], bus.VLD_I & bus.SOF_I};
      r_user_pipe <= {r_user_pipe[STAGES-1:1], bus.USER_I};
    end
  end

  assign bus.VLD_O  = r_vld_pipe[STAGES];
  assign bus.SOF_O  = r_sof_pipe[STAGES];
  assign bus.USER_O = r_user_pipe[STAGES];
  assign bus.R_O    = w_pix[0];
  assign bus.G_O    = w_pix[1];
  assign bus.B_O    = w_pix[2];
endmodule
